// File: rtl/pc_fetch_unit.sv
// PC holder and sequential fetch issuer with an in-order tag FIFO.
// Redirects/traps retarget the PC and mark in-flight responses as stale.
module pc_fetch_unit #(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int unsigned      INC          = 4,
    parameter int unsigned      DEPTH        = 4,
    parameter int unsigned      ALIGN_BITS   = 2,
    localparam int unsigned     CW           = $clog2(DEPTH + 1),
    localparam int unsigned     PW           = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_addr,
    output logic            req_valid,
    output logic [XLEN-1:0] req_addr,
    input  logic            req_ready,
    input  logic            rsp_valid,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] curr_addr,
    output logic [CW-1:0]   outstanding,
    output logic            misalign,
    output logic            rsp_err
);
    localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   cnt_q, cnt_d, disc_q, disc_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            misalign_q, misalign_d, rsp_err_q, rsp_err_d;
    logic [XLEN-1:0] fifo_mem [DEPTH];

    logic            redir, fire, pop;
    logic [XLEN-1:0] target;

    assign redir  = trap_valid | redirect_valid;
    assign target = trap_valid ? trap_addr : redirect_addr;

    assign req_valid = !stall && !redir && (cnt_q < CW'(DEPTH));
    assign fire      = req_valid && req_ready;
    assign pop       = rsp_valid && (cnt_q != '0);

    assign req_addr    = pc_q;
    assign curr_addr   = pc_q;
    assign outstanding = cnt_q;
    assign misalign    = misalign_q;
    assign rsp_err     = rsp_err_q;
    assign out_valid   = pop && (disc_q == '0);
    assign out_pc      = fifo_mem[rd_ptr_q];

    always_comb begin
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        disc_d     = disc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        misalign_d = 1'b0;
        rsp_err_d  = rsp_err_q;

        if (redir) begin
            pc_d       = target & ~ALIGN_MASK;
            misalign_d = |(target & ALIGN_MASK);
        end else if (fire) begin
            pc_d = pc_q + XLEN'(INC);
        end

        if (fire)
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        if (pop)
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);

        cnt_d = cnt_q + CW'(fire) - CW'(pop);

        // Everything still queued after this cycle's pop belongs to the old path.
        if (redir)
            disc_d = cnt_q - CW'(pop);
        else if (pop && disc_q != '0)
            disc_d = disc_q - CW'(1);

        if (rsp_valid && cnt_q == '0)
            rsp_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_VECTOR;
            cnt_q      <= '0;
            disc_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            misalign_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            disc_q     <= disc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            misalign_q <= misalign_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fire)
            fifo_mem[wr_ptr_q] <= pc_q;
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised successor to the single-cycle program counter, intended for the pipelined core.
- Holds the PC and issues sequential fetch addresses to instruction memory over a valid/ready request handshake.
- Tracks up to DEPTH outstanding requests in a FIFO, so each returning instruction is tagged with the PC that fetched it.
- Applies branch and trap redirects, discarding responses to requests that were in flight when a redirect occurred.

Parameters:
- XLEN, 32: PC and address width.
- RESET_VECTOR, 32'h0000_0000: PC value after reset.
- INC, 4: sequential PC increment.
- DEPTH, 4: maximum outstanding fetch requests (FIFO depth, ≥2).
- ALIGN_BITS, 2: number of PC LSBs that must be zero.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- stall  in  1  blocks new fetch issue
- redirect_valid  in  1  branch/jump redirect request
- redirect_addr  in  XLEN  branch/jump target
- trap_valid  in  1  trap redirect request; has priority over redirect_valid
- trap_addr  in  XLEN  trap handler address
- req_valid  out  1  fetch request valid
- req_addr  out  XLEN  fetch address; always equals curr_addr
- req_ready  in  1  memory accepts the request
- rsp_valid  in  1  memory returns one response, in order; no backpressure
- out_valid  out  1  live response present this cycle
- out_pc  out  XLEN  PC of the live response
- curr_addr  out  XLEN  current PC register
- outstanding  out  $clog2(DEPTH+1)  requests issued but not yet responded to, live and stale
- misalign  out  1  one-cycle pulse: the accepted redirect target was misaligned
- rsp_err  out  1  sticky: response arrived with outstanding == 0

Behaviour:
- Reset (rst low, asynchronous):
  - curr_addr = RESET_VECTOR.
  - FIFO empty; outstanding = 0; discard = 0.
  - misalign = 0; rsp_err = 0.
  - All state is cleared immediately, including mid-flight; responses to pre-reset requests are not tracked.
- Issue:
  - req_valid = !stall && !trap_valid && !redirect_valid && (outstanding < DEPTH).
  - fire = req_valid && req_ready.
  - On fire: push curr_addr into the FIFO; curr_addr <= curr_addr + INC, modulo 2^XLEN (e.g. 0xFFFF_FFFC -> 0x0).
  - req_valid is not gated by rsp_valid in the same cycle; there is no full-bypass.
- Redirect:
  - Target = trap_addr if trap_valid, else redirect_addr.
  - Next cycle curr_addr = target with its low ALIGN_BITS bits cleared.
  - misalign pulses one cycle if any of those bits were set.
  - Redirects take effect even while stall = 1.
  - No request issues in the redirect cycle.
- Flush on redirect:
  - discard <= outstanding − (rsp_valid ? 1 : 0).
  - All FIFO entries present after that cycle's pop become stale.
  - A redirect arriving while discard > 0 recomputes discard the same way; entries stay in order and no counts are double-counted.
- Response:
  - On rsp_valid with outstanding > 0: pop the FIFO head and decrement outstanding.
  - If discard > 0: decrement discard; out_valid = 0.
  - Otherwise: out_valid = 1 and out_pc = head PC, combinationally in the same cycle.
  - outstanding update: +1 on fire, −1 on pop; simultaneous fire and pop leaves it unchanged.
- Empty response:
  - rsp_valid with outstanding == 0 sets rsp_err, which stays set until reset.
  - No pop occurs; out_valid = 0.
- FIFO: circular pointers of $clog2(DEPTH) bits, wrap at DEPTH; outstanding is the occupancy count.
- Invariant: discard ≤ outstanding ≤ DEPTH at all times.

Test Plan:
1. Reset and sequential fetch: rst low then high, req_ready = 1, rsp_valid = 0 -> req_addr 0x0, 0x4, 0x8, 0xC; outstanding reaches 4; req_valid drops; curr_addr holds 0x10.
2. In-order responses: continuing from test 1, pulse rsp_valid four cycles with req_ready = 0 -> out_pc 0x0, 0x4, 0x8, 0xC with out_valid = 1 each cycle; outstanding returns to 0.
3. Redirect flush: 3 outstanding, redirect_valid with 0x200 -> curr_addr 0x200; the next 3 responses give out_valid = 0; the response to the first 0x200 request gives out_pc 0x200.
4. Trap priority and alignment: trap_valid with 0x80 and redirect_valid with 0x300 in the same cycle -> curr_addr 0x80; then redirect to 0x106 -> curr_addr 0x104, misalign pulses one cycle.
5. Stall and simultaneous events:
   - stall = 1 -> req_valid = 0 and curr_addr holds.
   - redirect during stall -> curr_addr still updates.
   - fire and rsp_valid in the same cycle -> outstanding unchanged.
6. Wrap, error and async reset:
   - curr_addr 0xFFFF_FFFC, one fire -> 0x0.
   - rsp_valid with outstanding 0 -> rsp_err = 1 and stays set.
   - rst low mid-cycle -> all outputs return to reset values before the next clock edge.
